apsk_control_master: RTL and testbench
======================================

Name: apsk_control_master

Overview:
- AXI4-Lite master that turns a simple command/response stream into single AXI4-Lite read or write transactions.
- Used by on-chip sequencers (boot-time config, bench harness) to program the APSK modulator control register slave (bits_per_symbol, offset_symbol_enable) without a CPU.
- One outstanding transaction at a time; keeps a saturating count of error responses.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width (32 or 64)
- C_M_AXI_ADDR_WIDTH, 4, AXI address width
- ERR_COUNT_WIDTH, 8, width of the saturating error counter

Ports:
- m_axi_aclk  in  1  single clock
- m_axi_aresetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP from the slave
- err_count  out  ERR_COUNT_WIDTH  saturating count of non-OKAY responses
- busy  out  1  high in any state other than IDLE
- m_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master directions and widths

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE. All valid/ready outputs are 0 except cmd_ready=1. Addr, data, strb, rsp_* and err_count are 0.
- awprot and arprot are tied to 3'b000.
- All AXI and response outputs are registered. cmd_ready = (state==IDLE) and is registered-equivalent.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - On cmd_valid, latch the command.
  - Write: go to WR_AW_W, awvalid=wvalid=1 in the next cycle.
  - Read: go to RD_AR, arvalid=1 in the next cycle.
  - Command-accept to VALID latency is 1 cycle.
- WR_AW_W:
  - awvalid and wvalid are asserted together in the same cycle (the slave requires both).
  - Each channel drops independently after its own handshake. Internal aw_done and w_done flags track this; either order and simultaneous completion are legal.
  - When both are done (including the completing cycle), go to WR_B with bready=1.
  - awaddr, wdata and wstrb are held stable while their valid is high.
- WR_B:
  - bready=1. On bvalid, capture bresp, set rsp_write=1, rsp_rdata=0, go to RSP, bready=0.
  - A bvalid seen outside WR_B is ignored (bready=0).
- RD_AR: arvalid held until arready. Then arvalid=0, rready=1, go to RD_R.
- RD_R: on rvalid, capture rdata and rresp, set rsp_write=0, rready=0, go to RSP.
- RSP:
  - rsp_valid=1 and rsp_* are stable until rsp_ready.
  - On the handshake: rsp_valid=0, go to IDLE, cmd_ready=1 in the next cycle.
  - Minimum command-to-command spacing is therefore accept, AXI phase(s), response, then IDLE. There is no back-to-back pipelining.
- err_count increments by 1 on capture of a response != 2'b00 and saturates at all-ones; no wrap.
- No timeout: a stalled slave leaves the FSM in the waiting state indefinitely, with busy=1.
- Reset mid-transaction: all valids drop immediately (async), and the in-flight command is lost with no response. The err_count value at reset is discarded.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Write with immediate slave: cmd write addr=0x0, wdata=0x0000_0013, wstrb=0xF.
  - Expect awvalid/wvalid high 1 cycle after accept; bready high after the AW/W handshake.
  - Expect rsp_valid with rsp_write=1, rsp_resp=0; slave bits_per_symbol=3, offset_symbol_enable=1.
- Read back: cmd read addr=0x0.
  - Expect arvalid then rready; rsp_rdata=0x0000_0013, rsp_resp=0, rsp_write=0.
- Split AW/W acceptance (custom slave, awready 3 cycles before wready):
  - Expect awvalid to drop after its handshake and wvalid to stay high until its own.
  - Expect exactly one B handshake and one response.
- Backpressure:
  - Hold rsp_ready=0 for 10 cycles: rsp_* stable, cmd_ready=0, cmd_valid ignored.
  - Release: IDLE and cmd_ready=1 on the next cycle.
- Error saturation with ERR_COUNT_WIDTH=2: slave returns bresp=2'b10 on 5 writes -> err_count 1,2,3,3,3 and rsp_resp=2'b10 each time.
- Async reset asserted in RD_R with rvalid pending:
  - Expect rready=0, busy=0, cmd_ready=1 immediately, rsp_valid never asserted.
  - After release, the next read completes normally.

Source files
------------

// File: rtl/apsk_control_master.sv
// AXI4-Lite master: turns a command/response stream into single AXI4-Lite reads or writes,
// one at a time, and keeps a saturating count of non-OKAY responses.
module apsk_control_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int ERR_COUNT_WIDTH    = 8
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_aresetn,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic [ERR_COUNT_WIDTH-1:0]        err_count,
    output logic                              busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] rst_sync;
    logic       rst_n;
    logic       aw_done;
    logic       w_done;
    logic       aw_fin;
    logic       w_fin;
    logic       capture;
    logic [1:0] resp_in;
    logic       err_inc;

    // Reset asserts immediately but is released two clock edges after the pin deasserts.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n        = rst_sync[1];
    assign cmd_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    always_ff @(posedge m_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        aw_fin     = aw_done | (m_axi_awvalid & m_axi_awready);
        w_fin      = w_done | (m_axi_wvalid & m_axi_wready);
        capture    = 1'b0;
        resp_in    = m_axi_rresp;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = cmd_write ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (aw_fin && w_fin) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                resp_in = m_axi_bresp;
                if (m_axi_bvalid) begin
                    capture    = 1'b1;
                    state_next = RSP;
                end
            end
            RD_AR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                if (m_axi_rvalid) begin
                    capture    = 1'b1;
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        err_inc = capture && (resp_in != 2'b00) && !(&err_count);
    end

    // Every AXI and response output is a flop updated on the transition that owns it.
    always_ff @(posedge m_axi_aclk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            err_count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        m_axi_awaddr <= cmd_addr;
                        m_axi_araddr <= cmd_addr;
                        m_axi_wdata  <= cmd_wdata;
                        m_axi_wstrb  <= cmd_wstrb;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                        end
                    end
                end
                WR_AW_W: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                    end
                end
                WR_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (err_inc) begin
                err_count <= err_count + ERR_COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_apsk_control_master.sv
// Bench for apsk_control_master: directed scenarios plus randomized traffic against a
// transaction-level model and a configurable-latency register slave.
module tb_apsk_control_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [1:0]  err_count;
    logic        busy;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apsk_control_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(4),
        .ERR_COUNT_WIDTH(2)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count), .busy(busy),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Slave knobs, changed only while no transaction is in flight.
    logic        err_mode = 1'b0;
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [31:0] s_mem [4];
    int          b_count = 0;
    logic        saw_split = 1'b0;

    initial begin
        logic        aw_have, w_have, b_pend, ar_have, r_pend;
        logic [3:0]  aw_a, ar_a, w_s;
        logic [31:0] w_d, r_d;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        for (int i = 0; i < 4; i++) s_mem[i] = '0;
        aw_have = 0; w_have = 0; b_pend = 0; ar_have = 0; r_pend = 0;
        aw_a = 0; ar_a = 0; w_s = 0; w_d = 0; r_d = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                aw_have = 0; w_have = 0; b_pend = 0; ar_have = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (awvalid && awready) begin aw_have = 1; aw_a = awaddr; aw_cnt = 0; end
                if (wvalid && wready) begin w_have = 1; w_d = wdata; w_s = wstrb; w_cnt = 0; end
                if (bvalid && bready) begin b_pend = 0; b_count++; end
                if (arvalid && arready) begin ar_have = 1; ar_a = araddr; ar_cnt = 0; end
                if (rvalid && rready) r_pend = 0;
                if (aw_have && w_have && !b_pend) begin
                    if (!err_mode) s_mem[aw_a[3:2]] = merge(s_mem[aw_a[3:2]], w_d, w_s);
                    aw_have = 0; w_have = 0; b_pend = 1; b_cnt = b_dly;
                end
                if (ar_have && !r_pend) begin
                    r_d = s_mem[ar_a[3:2]]; ar_have = 0; r_pend = 1; r_cnt = r_dly;
                end
            end
            #1;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (!awvalid && wvalid) saw_split = 1;
                awready = awvalid && !aw_have && (aw_cnt >= aw_dly);
                if (awvalid && !aw_have && !awready) aw_cnt++;
                wready = wvalid && !w_have && (w_cnt >= w_dly);
                if (wvalid && !w_have && !wready) w_cnt++;
                arready = arvalid && !ar_have && (ar_cnt >= ar_dly);
                if (arvalid && !ar_have && !arready) ar_cnt++;
                bvalid = b_pend && (b_cnt == 0);
                bresp  = err_mode ? 2'b10 : 2'b00;
                if (b_pend && b_cnt > 0) b_cnt--;
                rvalid = r_pend && (r_cnt == 0);
                rdata  = r_d;
                rresp  = err_mode ? 2'b10 : 2'b00;
                if (r_pend && r_cnt > 0) r_cnt--;
            end
        end
    end

    // Transaction-level model of what the master must be doing at each point.
    typedef struct packed {
        logic        write;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } txn_t;

    txn_t        m_cur = '0;
    logic        m_busy = 0, m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0, m_rsp = 0;
    logic [1:0]  m_err = 0;
    int          m_rel = 0;
    logic [31:0] ref_mem [4] = '{default: 32'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_aw <= 0; m_w <= 0; m_b <= 0; m_ar <= 0; m_r <= 0; m_rsp <= 0;
            m_err <= 0; m_rel <= 0;
        end else if (m_rel < 2) begin
            m_rel <= m_rel + 1;
        end else begin
            if (cmd_valid && !m_busy) begin
                m_busy      <= 1;
                m_cur.write <= cmd_write;
                m_cur.addr  <= cmd_addr;
                m_cur.wdata <= cmd_wdata;
                m_cur.wstrb <= cmd_wstrb;
                m_cur.resp  <= err_mode ? 2'b10 : 2'b00;
                if (cmd_write) begin
                    m_aw <= 1; m_w <= 1; m_cur.rdata <= 0;
                    if (!err_mode) ref_mem[cmd_addr[3:2]] <= merge(ref_mem[cmd_addr[3:2]], cmd_wdata, cmd_wstrb);
                end else begin
                    m_ar <= 1; m_cur.rdata <= ref_mem[cmd_addr[3:2]];
                end
            end
            if (m_aw && awready) m_aw <= 0;
            if (m_w && wready) m_w <= 0;
            if ((m_aw || m_w) && (!m_aw || awready) && (!m_w || wready)) m_b <= 1;
            if (m_b && bvalid) begin
                m_b <= 0; m_rsp <= 1;
                if (m_cur.resp != 0 && m_err != 2'd3) m_err <= m_err + 2'd1;
            end
            if (m_ar && arready) begin m_ar <= 0; m_r <= 1; end
            if (m_r && rvalid) begin
                m_r <= 0; m_rsp <= 1;
                if (m_cur.resp != 0 && m_err != 2'd3) m_err <= m_err + 2'd1;
            end
            if (m_rsp && rsp_ready) begin m_rsp <= 0; m_busy <= 0; end
        end
    end

    always @(negedge clk) begin
        check_output("cmd_ready", cmd_ready, !m_busy);
        check_output("busy", busy, m_busy);
        check_output("awvalid", awvalid, m_aw);
        check_output("wvalid", wvalid, m_w);
        check_output("bready", bready, m_b);
        check_output("arvalid", arvalid, m_ar);
        check_output("rready", rready, m_r);
        check_output("rsp_valid", rsp_valid, m_rsp);
        check_output("err_count", err_count, m_err);
        check_output("prot", {awprot, arprot}, 6'd0);
        if (m_aw) check_output("awaddr", awaddr, m_cur.addr);
        if (m_w) check_output("wdata_wstrb", {wdata, wstrb}, {m_cur.wdata, m_cur.wstrb});
        if (m_ar) check_output("araddr", araddr, m_cur.addr);
        if (m_rsp) begin
            check_output("rsp_write", rsp_write, m_cur.write);
            check_output("rsp_resp", rsp_resp, m_cur.resp);
            check_output("rsp_rdata", rsp_rdata, m_cur.rdata);
        end
    end

    task automatic apply_stimulus(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, input int hold, input logic junk,
                                  output logic o_write, output logic [31:0] o_rdata,
                                  output logic [1:0] o_resp, output logic [1:0] o_err);
        int   n;
        logic acc;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        acc = 0; n = 0;
        while (!acc && n < 100) begin @(posedge clk); acc = cmd_ready; n++; end
        #1 cmd_valid = 0;
        check_output("cmd_accept", acc, 1);
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        check_output("rsp_arrive", rsp_valid, 1);
        if (junk) begin
            cmd_valid = 1; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~data;
        end
        repeat (hold) begin @(posedge clk); #1; end
        cmd_valid = 0; rsp_ready = 1;
        @(posedge clk);
        o_write = rsp_write; o_rdata = rsp_rdata; o_resp = rsp_resp; o_err = err_count;
        #1 rsp_ready = 0;
    endtask

    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        logic        r_write;
        logic [31:0] r_rdata;
        logic [1:0]  r_resp, r_err;
        int          n, bc;
        logic        acc;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_cmd_ready", cmd_ready, 1);
        check_output("reset_valids", {busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'd0);
        check_output("reset_data", {err_count, rsp_rdata, rsp_resp, awaddr, wdata, wstrb}, 0);
        rst_n = 1;
        repeat (4) begin @(posedge clk); #1; end

        apply_stimulus(1, 4'h0, 32'h0000_0013, 4'hF, 0, 0, r_write, r_rdata, r_resp, r_err);
        check_output("wr_rsp_write", r_write, 1);
        check_output("wr_rsp_resp", r_resp, 2'b00);
        check_output("slave_bits_per_symbol", s_mem[0][3:0], 4'd3);
        check_output("slave_offset_enable", s_mem[0][4], 1);

        apply_stimulus(0, 4'h0, 32'h0, 4'h0, 0, 0, r_write, r_rdata, r_resp, r_err);
        check_output("rd_rsp_rdata", r_rdata, 32'h0000_0013);
        check_output("rd_rsp_write", r_write, 0);
        check_output("rd_rsp_resp", r_resp, 2'b00);

        aw_dly = 0; w_dly = 3; bc = b_count; saw_split = 0;
        apply_stimulus(1, 4'h4, 32'hA5A5_0001, 4'hF, 0, 0, r_write, r_rdata, r_resp, r_err);
        check_output("split_b_count", b_count - bc, 1);
        check_output("split_aw_first", saw_split, 1);
        w_dly = 0;

        apply_stimulus(1, 4'h8, 32'h1234_5678, 4'h3, 10, 1, r_write, r_rdata, r_resp, r_err);
        check_output("bp_cmd_ready_after", {cmd_ready, busy}, 2'b10);

        err_mode = 1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 4'h0, $urandom, 4'hF, 0, 0, r_write, r_rdata, r_resp, r_err);
            check_output("sat_err_count", r_err, sat_exp[i]);
            check_output("sat_rsp_resp", r_resp, 2'b10);
        end
        err_mode = 0;

        // Reset while the read data phase is still outstanding.
        r_dly = 6;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0;
        acc = 0; n = 0;
        while (!acc && n < 100) begin @(posedge clk); acc = cmd_ready; n++; end
        #1 cmd_valid = 0;
        check_output("rst_cmd_accept", acc, 1);
        n = 0;
        while (!rready && n < 50) begin @(posedge clk); #1; n++; end
        check_output("rst_rready_rise", rready, 1);
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 0;
        #1;
        check_output("rst_immediate", {rready, busy, cmd_ready, rsp_valid, arvalid}, 5'b00100);
        check_output("rst_err_cleared", err_count, 2'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        r_dly = 0;
        repeat (4) begin @(posedge clk); #1; end
        apply_stimulus(0, 4'h0, 32'h0, 4'h0, 0, 0, r_write, r_rdata, r_resp, r_err);
        check_output("post_rst_rdata0", r_rdata, 32'h0000_0013);
        apply_stimulus(0, 4'h8, 32'h0, 4'h0, 0, 0, r_write, r_rdata, r_resp, r_err);
        check_output("post_rst_rdata8", r_rdata, 32'h0000_5678);

        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            err_mode = ($urandom_range(0, 3) == 0);
            apply_stimulus($urandom_range(0, 1), 4'($urandom), $urandom, 4'($urandom),
                           $urandom_range(0, 3), 1'($urandom), r_write, r_rdata, r_resp, r_err);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
